// File: rtl/fpu_addsub_seq_pkg.sv
// rtl/fpu_addsub_seq_pkg.sv - shared types and constants for the sequential float add/sub unit
// Contents: State_e result status, phase_e FSM phases, GRS_W guard/round/sticky width.
package fpu_addsub_seq_pkg;

    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        INEXACT   = 2'd1,
        OVERFLOW  = 2'd2,
        UNDERFLOW = 2'd3
    } State_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } phase_e;

    localparam int GRS_W = 3;

endpackage

// File: rtl/fpu_addsub_seq_if.sv
// rtl/fpu_addsub_seq_if.sv - request/result bundle of the sequential float add/sub unit
// master drives start/op_sub/op_a_in/op_b_in and observes busy/done/data_out/state_out;
// slave is the arithmetic unit side.
interface fpu_addsub_seq_if #(
    parameter int W = 32
);
    import fpu_addsub_seq_pkg::*;

    logic         start;
    logic         op_sub;
    logic [W-1:0] op_a_in;
    logic [W-1:0] op_b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] data_out;
    State_e       state_out;

    modport master (
        output start, op_sub, op_a_in, op_b_in,
        input  busy, done, data_out, state_out
    );

    modport slave (
        input  start, op_sub, op_a_in, op_b_in,
        output busy, done, data_out, state_out
    );

endinterface

// File: rtl/fpu_lzc.sv
// rtl/fpu_lzc.sv - leading-zero counter
// Ports: i_data (WIDTH) word to scan from the MSB; o_count (CW) number of leading zeros,
// WIDTH when i_data is all zero.
module fpu_lzc #(
    parameter int WIDTH = 27,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [CW-1:0]    o_count
);

    logic w_found;

    always_comb begin
        w_found = 1'b0;
        o_count = CW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!w_found && i_data[i]) begin
                o_count = CW'(WIDTH - 1 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_addsub_seq.sv
// rtl/fpu_addsub_seq.sv - multi-cycle float add/subtract with round-to-nearest-even
// Ports: clock, reset (sync, active high); bus (slave): start/op_sub/op_a_in/op_b_in request,
// busy/done handshake, data_out/state_out result held until the next done.
module fpu_addsub_seq
    import fpu_addsub_seq_pkg::*;
#(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25,
    parameter int BIAS  = 2**(EXP_W-1) - 1
) (
    input  logic            clock,
    input  logic            reset,
    fpu_addsub_seq_if.slave bus
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int FW = MAN_W + 1 + GRS_W;     // {hidden, fraction, G, R, S}
    localparam int SW = FW + 1;                // adder width with carry-out
    localparam int LW = MAN_W + 2;             // lzc scans mantissa and G
    localparam int CW = $clog2(LW + 1);
    localparam int XW = EXP_W + 2;             // signed exponent, never wraps

    localparam logic [EXP_W-1:0]     DIFF_MAX = EXP_W'(MAN_W + GRS_W);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    // all-ones biased exponent; BIAS is 2**(EXP_W-1)-1, so 2*BIAS+1 = 2**EXP_W-1
    localparam logic signed [XW-1:0] EXP_MAX  = XW'(2 * BIAS + 1);

    phase_e r_state, w_next;

    logic [W-1:0]           r_a, r_b;
    logic                   r_op_sub;
    logic                   r_sign, r_eff_sub;
    logic signed [XW-1:0]   r_exp;
    logic [FW-1:0]          r_x, r_y;
    logic [SW-1:0]          r_sum;
    logic [FW-1:0]          r_norm;
    logic [W-1:0]           r_data;
    State_e                 r_status;

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_next = ALIGN;
            ALIGN:   w_next = ADD;
            ADD:     w_next = NORM;
            NORM:    w_next = ROUND;
            ROUND:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign bus.busy      = (r_state != IDLE);
    assign bus.done      = (r_state == DONE);
    assign bus.data_out  = r_data;
    assign bus.state_out = r_status;

    // ---------------- ALIGN ----------------
    logic [EXP_W-1:0] w_exp_a, w_exp_b, w_exp_x, w_exp_y, w_diff;
    logic [MAN_W:0]   w_man_a, w_man_b, w_man_x, w_man_y;
    logic             w_sign_b, w_sign_x, w_swap;
    logic [2*FW-1:0]  w_y_ext;
    logic [FW-1:0]    w_y_al;

    always_comb begin
        w_exp_a  = r_a[W-2 -: EXP_W];
        w_exp_b  = r_b[W-2 -: EXP_W];
        w_man_a  = {(w_exp_a != '0), r_a[MAN_W-1:0]};
        w_man_b  = {(w_exp_b != '0), r_b[MAN_W-1:0]};
        w_sign_b = r_b[W-1] ^ r_op_sub;
        // {exp, fraction} orders magnitudes, so a plain unsigned compare picks X
        w_swap   = (r_b[W-2:0] > r_a[W-2:0]);
        if (w_swap) begin
            w_exp_x = w_exp_b;  w_man_x = w_man_b;  w_sign_x = w_sign_b;
            w_exp_y = w_exp_a;  w_man_y = w_man_a;
        end else begin
            w_exp_x = w_exp_a;  w_man_x = w_man_a;  w_sign_x = r_a[W-1];
            w_exp_y = w_exp_b;  w_man_y = w_man_b;
        end
        w_diff  = w_exp_x - w_exp_y;
        // lower half catches every bit shifted past the sticky position
        w_y_ext = {w_man_y, {(GRS_W + FW){1'b0}}} >> w_diff;
        if (w_diff > DIFF_MAX)
            w_y_al = {{(FW-1){1'b0}}, |w_man_y};
        else
            w_y_al = {w_y_ext[2*FW-1:FW+1], w_y_ext[FW] | (|w_y_ext[FW-1:0])};
    end

    // ---------------- NORM ----------------
    logic [CW-1:0]        w_lz;
    logic signed [XW-1:0] w_lz_s, w_lim, w_shift;
    logic [FW-1:0]        w_norm_sh;

    fpu_lzc #(.WIDTH(LW), .CW(CW)) u_lzc (
        .i_data  (r_sum[FW-1:GRS_W-1]),
        .o_count (w_lz)
    );

    always_comb begin
        w_lz_s    = $signed(XW'(w_lz));
        // keep the biased exponent at 1 or above; results still below that underflow
        w_lim     = (r_exp > EXP_ONE) ? (r_exp - EXP_ONE) : EXP_ZERO;
        w_shift   = (w_lz_s < w_lim) ? w_lz_s : w_lim;
        w_norm_sh = r_sum[FW-1:0] << $unsigned(w_shift);
    end

    // ---------------- ROUND / classify ----------------
    logic [MAN_W:0]       w_man_r, w_man_fin;
    logic [MAN_W+1:0]     w_man_rnd;
    logic                 w_g, w_r, w_s, w_inexact, w_inc;
    logic signed [XW-1:0] w_exp_fin;
    logic [W-1:0]         w_data;
    State_e               w_status;

    always_comb begin
        w_man_r   = r_norm[FW-1:GRS_W];
        w_g       = r_norm[GRS_W-1];
        w_r       = r_norm[GRS_W-2];
        w_s       = r_norm[0];
        w_inexact = w_g | w_r | w_s;
        w_inc     = w_g & (w_r | w_s | w_man_r[0]);
        w_man_rnd = {1'b0, w_man_r} + {{(MAN_W+1){1'b0}}, w_inc};
        if (w_man_rnd[MAN_W+1]) begin
            w_man_fin = w_man_rnd[MAN_W+1:1];
            w_exp_fin = r_exp + EXP_ONE;
        end else begin
            w_man_fin = w_man_rnd[MAN_W:0];
            w_exp_fin = r_exp;
        end

        w_data   = '0;
        w_status = EXACT;
        if (r_norm == '0) begin
            w_data   = '0;
            w_status = EXACT;
        end else if (w_exp_fin > EXP_MAX) begin
            w_data   = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_status = OVERFLOW;
        end else if ((w_exp_fin <= EXP_ZERO) || !w_man_fin[MAN_W]) begin
            w_data   = {r_sign, {(W-1){1'b0}}};
            w_status = UNDERFLOW;
        end else begin
            w_data   = {r_sign, w_exp_fin[EXP_W-1:0], w_man_fin[MAN_W-1:0]};
            w_status = w_inexact ? INEXACT : EXACT;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clock) begin
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    r_a      <= bus.op_a_in;
                    r_b      <= bus.op_b_in;
                    r_op_sub <= bus.op_sub;
                end
            end
            ALIGN: begin
                r_x       <= {w_man_x, {GRS_W{1'b0}}};
                r_y       <= w_y_al;
                r_sign    <= w_sign_x;
                r_eff_sub <= r_a[W-1] ^ w_sign_b;
                r_exp     <= $signed({2'b00, w_exp_x});
            end
            ADD: begin
                r_sum <= r_eff_sub ? ({1'b0, r_x} - {1'b0, r_y})
                                   : ({1'b0, r_x} + {1'b0, r_y});
            end
            NORM: begin
                if (r_sum[SW-1]) begin
                    r_norm <= {r_sum[SW-1:2], r_sum[1] | r_sum[0]};
                    r_exp  <= r_exp + EXP_ONE;
                end else begin
                    r_norm <= w_norm_sh;
                    r_exp  <= r_exp - w_shift;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_data   <= '0;
            r_status <= EXACT;
        end else if (r_state == ROUND) begin
            r_data   <= w_data;
            r_status <= w_status;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_seq.sv
// tb/tb_fpu_addsub_seq.sv - scoreboard bench for fpu_addsub_seq with an exact-arithmetic model
module tb_fpu_addsub_seq;
    import fpu_addsub_seq_pkg::*;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        State_e      st;
        logic [31:0] d;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   n_done = 0;
    exp_t exp_q[$];

    always #5 clock = ~clock;

    fpu_addsub_seq_if #(.W(32)) bus ();

    fpu_addsub_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                input State_e st, input logic [31:0] d);
        exp_t r;
        r.a = a; r.b = b; r.sub = sub; r.st = st; r.d = d;
        return r;
    endfunction

    // Exact value of an operand is {hidden,fraction} * 2^exp (common scale), so the
    // true sum is formed exactly and then rounded to nearest-even in one step.
    function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic         sa, sb, sign, inexact;
        int           ea, eb, emin, p, e, k;
        logic [127:0] ma, mb, va, vb, mag, q, rem, half;
        exp_t         r;
        r = mk(a, b, sub, EXACT, 32'h0);
        sa = a[31];
        sb = b[31] ^ sub;
        ea = int'(a[30:25]);
        eb = int'(b[30:25]);
        ma = '0; ma[25:0] = {(a[30:25] != 6'd0), a[24:0]};
        mb = '0; mb[25:0] = {(b[30:25] != 6'd0), b[24:0]};
        emin = (ea < eb) ? ea : eb;
        va = ma << (ea - emin);
        vb = mb << (eb - emin);
        if (sa == sb)      begin mag = va + vb; sign = sa; end
        else if (va >= vb) begin mag = va - vb; sign = sa; end
        else               begin mag = vb - va; sign = sb; end
        if (mag == 0) return r;
        if (ea == 0 && eb == 0) begin
            r.st = UNDERFLOW; r.d = {sign, 31'h0};
            return r;
        end
        p = 127;
        while (!mag[p]) p--;
        e = p + emin - 25;
        if (e < 1) e = 1;
        k = e - emin;
        if (k <= 0) begin
            q = mag << (-k);
            inexact = 1'b0;
        end else begin
            rem  = mag & ((128'd1 << k) - 128'd1);
            q    = mag >> k;
            half = 128'd1 << (k - 1);
            inexact = (rem != 0);
            if (rem > half || (rem == half && q[0])) q = q + 128'd1;
        end
        if (q[26]) begin q = q >> 1; e++; end
        if (e > 63) begin
            r.st = OVERFLOW; r.d = {sign, 6'h3f, 25'h0};
        end else if (!q[25]) begin
            r.st = UNDERFLOW; r.d = {sign, 31'h0};
        end else begin
            r.st = inexact ? INEXACT : EXACT;
            r.d  = {sign, 6'(e), q[24:0]};
        end
        return r;
    endfunction

    // Monitor: every done pulse consumes one scoreboard entry.
    always @(negedge clock) begin
        if (!reset && bus.done) begin
            exp_t w;
            n_done++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done got data=%h state=%0d want no done", bus.data_out, bus.state_out);
            end else begin
                w = exp_q.pop_front();
                if (bus.data_out !== w.d || bus.state_out !== w.st) begin
                    bad++;
                    $display("FAIL result a=%h b=%h sub=%0d got=%h/%0d want=%h/%0d",
                             w.a, w.b, w.sub, bus.data_out, bus.state_out, w.d, w.st);
                end
            end
        end
    end

    // Called at a negedge with the unit idle; returns at a negedge with the unit idle.
    task automatic run_op(input exp_t want);
        exp_q.push_back(want);
        bus.op_a_in = want.a;
        bus.op_b_in = want.b;
        bus.op_sub  = want.sub;
        bus.start   = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clock);
            bus.start = 1'b0;
            check($sformatf("busy_c%0d", c), 32'(bus.busy), 32'd1);
            check($sformatf("done_c%0d", c), 32'(bus.done), (c == 5) ? 32'd1 : 32'd0);
        end
        @(negedge clock);
        check("busy_after", 32'(bus.busy), 32'd0);
        check("done_after", 32'(bus.done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b;
        logic        s;
        int          mode, d0;

        bus.start = 1'b0; bus.op_sub = 1'b0; bus.op_a_in = '0; bus.op_b_in = '0;
        repeat (3) @(negedge clock);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_done",  32'(bus.done), 32'd0);
        check("rst_data",  bus.data_out, 32'h0);
        check("rst_state", 32'(bus.state_out), 32'(EXACT));
        reset = 1'b0;

        run_op(mk(32'h3E000000, 32'h3E000000, 1'b0, EXACT,     32'h40000000));
        run_op(mk(32'h3E000000, 32'h3E000000, 1'b1, EXACT,     32'h00000000));
        run_op(mk(32'h3E000000, 32'h0A000000, 1'b0, INEXACT,   32'h3E000000));
        run_op(mk(32'h3E000001, 32'h0A000000, 1'b0, INEXACT,   32'h3E000002));
        run_op(mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, OVERFLOW,  32'h7E000000));
        run_op(mk(32'h02000000, 32'h02000001, 1'b1, UNDERFLOW, 32'h80000000));

        // start while busy (cycle 2) and in the DONE cycle (cycle 5) is ignored
        d0 = n_done;
        exp_q.push_back(mk(32'h3E000000, 32'h3E000000, 1'b0, EXACT, 32'h40000000));
        bus.op_a_in = 32'h3E000000; bus.op_b_in = 32'h3E000000; bus.op_sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock);
        bus.op_a_in = 32'h7FFFFFFF; bus.op_b_in = 32'h12345678; bus.op_sub = 1'b1;
        bus.start = 1'b1;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("hs_done_c5", 32'(bus.done), 32'd1);
        bus.start = 1'b1;
        @(negedge clock); bus.start = 1'b0;
        check("hs_idle_c6", 32'(bus.busy), 32'd0);
        repeat (8) @(negedge clock);
        check("hs_one_done", 32'(n_done - d0), 32'd1);

        // reset at cycle 3 aborts the operation
        d0 = n_done;
        bus.op_a_in = 32'h7FFFFFFF; bus.op_b_in = 32'h7FFFFFFF; bus.op_sub = 1'b0;
        bus.start = 1'b1;
        @(negedge clock); bus.start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort_busy",  32'(bus.busy), 32'd0);
        check("abort_done",  32'(bus.done), 32'd0);
        check("abort_data",  bus.data_out, 32'h0);
        check("abort_state", 32'(bus.state_out), 32'(EXACT));
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        run_op(mk(32'h3E000000, 32'h3E000000, 1'b0, EXACT, 32'h40000000));

        for (int i = 0; i < 150; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 4);
            if (mode == 1)      b[30:25] = a[30:25];
            else if (mode == 2) b[30:25] = a[30:25] + 6'd1;
            else if (mode == 3) b[30:25] = a[30:25] - 6'($urandom_range(24, 31));
            else if (mode == 4) begin
                a[30:25] = 6'($urandom_range(0, 3));
                b = {a[31:8], 8'($urandom)};
            end
            run_op(ref_model(a, b, s));
        end

        repeat (3) @(negedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
